// File: rtl/decimating_comb_pkg.sv
// Shared types and constants for the decimating comb stage and its helpers.
package decimating_comb_pkg;

    // Clip indicators produced by a saturating subtract.
    typedef struct packed {
        logic of;
        logic uf;
    } sat_flags_t;

    // Largest positive value representable in a len-bit two's complement word.
    function automatic int sat_max(input int len);
        return (1 << (len - 1)) - 1;
    endfunction

    // Most negative value representable in a len-bit two's complement word.
    function automatic int sat_min(input int len);
        return -(1 << (len - 1));
    endfunction

    // Width of a phase counter covering 0..ratio-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int ratio);
        return (ratio <= 2) ? 1 : $clog2(ratio);
    endfunction

endpackage

// File: rtl/decimating_comb_sat_sub.sv
// Saturating subtract a - b for signed LENGTH-bit operands; the difference is
// formed one bit wider so the clip decision sees the true result.
module sat_sub
    import decimating_comb_pkg::*;
#(
    parameter int LENGTH = 5
) (
    input  logic signed [LENGTH-1:0] a_i,
    input  logic signed [LENGTH-1:0] b_i,
    output logic signed [LENGTH-1:0] data_o,
    output sat_flags_t               flags_o
);

    localparam logic signed [LENGTH:0]   MAX_W = (LENGTH + 1)'(sat_max(LENGTH));
    localparam logic signed [LENGTH:0]   MIN_W = (LENGTH + 1)'(sat_min(LENGTH));
    localparam logic signed [LENGTH-1:0] MAX_N = LENGTH'(sat_max(LENGTH));
    localparam logic signed [LENGTH-1:0] MIN_N = LENGTH'(sat_min(LENGTH));

    logic signed [LENGTH:0] diff;

    // Wide difference, then clip to the output range and flag which rail was hit.
    always_comb begin
        diff    = {a_i[LENGTH-1], a_i} - {b_i[LENGTH-1], b_i};
        data_o  = diff[LENGTH-1:0];
        flags_o = '0;
        if (diff > MAX_W) begin
            data_o     = MAX_N;
            flags_o.of = 1'b1;
        end else if (diff < MIN_W) begin
            data_o     = MIN_N;
            flags_o.uf = 1'b1;
        end
    end

endmodule

// File: rtl/decimating_comb.sv
// Decimating comb: keeps one sample in RATIO and emits the saturated
// difference against the sample DELAY decimated steps earlier, together with
// a tag telling whether the upstream integrator saturated during the window.
module decimating_comb
    import decimating_comb_pkg::*;
#(
    parameter int LENGTH    = 5,
    parameter int RATIO     = 4,
    parameter int DELAY     = 1,
    parameter bit INPUT_REG = 1'b1
) (
    input  logic              CLK_I,
    input  logic              RESET_I,
    input  logic [LENGTH-1:0] DATA_I,
    input  logic              OFDET_I,
    input  logic              UFDET_I,
    output logic [LENGTH-1:0] DATA_O,
    output logic              VALID_O,
    output logic              OFDET_O,
    output logic              UFDET_O,
    output logic              SATIN_O
);

    localparam int            CW       = cnt_width(RATIO);
    localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);

    // Input stage values seen by the rest of the datapath.
    logic signed [LENGTH-1:0] s_data;
    logic                     s_of;
    logic                     s_uf;

    if (INPUT_REG) begin : g_inreg
        logic signed [LENGTH-1:0] s_data_q;
        logic                     s_of_q;
        logic                     s_uf_q;

        // Register the integrator outputs before use.
        always_ff @(posedge CLK_I) begin
            if (RESET_I) begin
                s_data_q <= '0;
                s_of_q   <= 1'b0;
                s_uf_q   <= 1'b0;
            end else begin
                s_data_q <= DATA_I;
                s_of_q   <= OFDET_I;
                s_uf_q   <= UFDET_I;
            end
        end

        assign s_data = s_data_q;
        assign s_of   = s_of_q;
        assign s_uf   = s_uf_q;
    end else begin : g_noreg
        assign s_data = DATA_I;
        assign s_of   = OFDET_I;
        assign s_uf   = UFDET_I;
    end

    logic [CW-1:0]            cnt_q;
    logic [CW-1:0]            cnt_d;
    logic                     dec_edge;
    logic                     win_q;
    logic                     win_d;
    logic signed [LENGTH-1:0] dly_q [DELAY];
    logic signed [LENGTH-1:0] sub_data;
    sat_flags_t               sub_flags;

    logic [LENGTH-1:0]        data_q;
    logic                     valid_q;
    logic                     of_q;
    logic                     uf_q;
    logic                     satin_q;

    // Phase counter and window accumulation; a flag on the decimation cycle
    // itself is folded into the window that closes on that cycle.
    always_comb begin
        dec_edge = (cnt_q == CNT_LAST);
        cnt_d    = dec_edge ? '0 : cnt_q + CW'(1);
        win_d    = win_q | s_of | s_uf;
    end

    // Difference between the current sample and the oldest delay-line entry.
    sat_sub #(
        .LENGTH (LENGTH)
    ) u_sat_sub (
        .a_i     (s_data),
        .b_i     (dly_q[DELAY-1]),
        .data_o  (sub_data),
        .flags_o (sub_flags)
    );

    // Counter, window flag, delay line and output registers; reset wins over
    // a decimation edge in the same cycle and discards a partial window.
    always_ff @(posedge CLK_I) begin
        if (RESET_I) begin
            cnt_q   <= '0;
            win_q   <= 1'b0;
            for (int i = 0; i < DELAY; i++) begin
                dly_q[i] <= '0;
            end
            data_q  <= '0;
            valid_q <= 1'b0;
            of_q    <= 1'b0;
            uf_q    <= 1'b0;
            satin_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= dec_edge;
            if (dec_edge) begin
                win_q   <= 1'b0;
                data_q  <= sub_data;
                of_q    <= sub_flags.of;
                uf_q    <= sub_flags.uf;
                satin_q <= win_d;
                for (int i = DELAY - 1; i > 0; i--) begin
                    dly_q[i] <= dly_q[i-1];
                end
                dly_q[0] <= s_data;
            end else begin
                win_q <= win_d;
            end
        end
    end

    assign DATA_O  = data_q;
    assign VALID_O = valid_q;
    assign OFDET_O = of_q;
    assign UFDET_O = uf_q;
    assign SATIN_O = satin_q;

endmodule

// File: tb/tb_decimating_comb.sv
// Directed bench for decimating_comb: two instances (DELAY=1 and DELAY=2) share
// one stimulus stream; expected strobes are queued when the captured sample is
// driven and compared when the strobe edge arrives.
module tb_decimating_comb;

    localparam int LEN   = 5;
    localparam int RATIO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst = 1'b1;
    logic signed [LEN-1:0] din = 5'sd7;
    logic                  ofi = 1'b0;
    logic                  ufi = 1'b0;

    logic [LEN-1:0] d1_data, d2_data;
    logic           d1_valid, d1_of, d1_uf, d1_satin;
    logic           d2_valid, d2_of, d2_uf, d2_satin;

    decimating_comb #(.LENGTH(LEN), .RATIO(RATIO), .DELAY(1), .INPUT_REG(1'b1)) dut1 (
        .CLK_I(clk), .RESET_I(rst), .DATA_I(din), .OFDET_I(ofi), .UFDET_I(ufi),
        .DATA_O(d1_data), .VALID_O(d1_valid), .OFDET_O(d1_of), .UFDET_O(d1_uf),
        .SATIN_O(d1_satin)
    );

    decimating_comb #(.LENGTH(LEN), .RATIO(RATIO), .DELAY(2), .INPUT_REG(1'b1)) dut2 (
        .CLK_I(clk), .RESET_I(rst), .DATA_I(din), .OFDET_I(ofi), .UFDET_I(ufi),
        .DATA_O(d2_data), .VALID_O(d2_valid), .OFDET_O(d2_of), .UFDET_O(d2_uf),
        .SATIN_O(d2_satin)
    );

    typedef struct {
        logic signed [LEN-1:0] data;
        logic                  of;
        logic                  uf;
        logic                  satin;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t last1, last2;

    int checks = 0;
    int errors = 0;
    int e = 0;                       // edges since reset release
    logic                  flg_h[$]; // OFDET_I|UFDET_I sampled at edge k (index k-1)
    logic signed [LEN-1:0] caps[$];  // samples captured at strobes since reset

    function automatic exp_t zero_exp();
        exp_t z;
        z.data = '0; z.of = 1'b0; z.uf = 1'b0; z.satin = 1'b0;
        return z;
    endfunction

    // Expected comb output for captured sample x against the one m strobes back.
    function automatic exp_t model(input logic signed [LEN-1:0] x, input int m, input logic sat);
        exp_t r;
        int xi, xm, d;
        xi = x;
        xm = 0;
        if (caps.size() >= m) xm = caps[caps.size() - m];
        d = xi - xm;
        r = zero_exp();
        r.satin = sat;
        if (d > 15) begin
            r.data = 5'sd15; r.of = 1'b1;
        end else if (d < -16) begin
            r.data = -5'sd16; r.uf = 1'b1;
        end else begin
            r.data = LEN'(d);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic check_one(input string nm, input logic v_obs, input logic [LEN-1:0] d_obs,
                             input logic of_obs, input logic uf_obs, input logic sat_obs,
                             input logic v_exp, input exp_t ex);
        chk({nm, "_valid"}, v_obs, v_exp);
        chk({nm, "_data"}, $signed(d_obs), ex.data);
        chk({nm, "_of"}, of_obs, ex.of);
        chk({nm, "_uf"}, uf_obs, ex.uf);
        chk({nm, "_satin"}, sat_obs, ex.satin);
    endtask

    // One clock: drive inputs, update the expectation model, check both DUTs.
    task automatic step(input logic r, input logic signed [LEN-1:0] d, input logic o, input logic u);
        logic v_exp;
        logic sat;
        exp_t ex1, ex2;
        @(negedge clk);
        rst = r; din = d; ofi = o; ufi = u;
        v_exp = 1'b0;
        if (r) begin
            e = 0;
            q1.delete(); q2.delete(); flg_h.delete(); caps.delete();
            last1 = zero_exp(); last2 = zero_exp();
        end else begin
            e++;
            flg_h.push_back(o | u);
            if (e % RATIO == RATIO - 1) begin
                // This sample is captured at the next edge; its window spans
                // input edges e-3..e (edges before release excluded).
                sat = 1'b0;
                for (int k = (e - 3 > 1 ? e - 3 : 1); k <= e; k++) sat |= flg_h[k-1];
                q1.push_back(model(d, 1, sat));
                q2.push_back(model(d, 2, sat));
                caps.push_back(d);
            end
            v_exp = (e % RATIO == 0);
        end
        @(posedge clk);
        #1;
        if (v_exp) begin
            if (q1.size() == 0 || q2.size() == 0) begin
                checks++; errors++;
                $error("FAIL scoreboard_empty observed=empty expected=entry (t=%0t)", $time);
                ex1 = last1; ex2 = last2;
            end else begin
                ex1 = q1.pop_front(); ex2 = q2.pop_front();
                last1 = ex1; last2 = ex2;
            end
        end else begin
            ex1 = last1; ex2 = last2;
        end
        check_one("d1", d1_valid, d1_data, d1_of, d1_uf, d1_satin, v_exp, ex1);
        check_one("d2", d2_valid, d2_data, d2_of, d2_uf, d2_satin, v_exp, ex2);
    endtask

    // Four cycles of constant data with an optional flag pulse at phase pos.
    task automatic window(input logic signed [LEN-1:0] v, input int pos, input logic o, input logic u);
        for (int j = 0; j < RATIO; j++) begin
            if (j == pos) step(1'b0, v, o, u);
            else          step(1'b0, v, 1'b0, 1'b0);
        end
    endtask

    initial begin
        last1 = zero_exp();
        last2 = zero_exp();

        // Reset hold with non-zero input: outputs stay 0.
        repeat (3) step(1'b1, 5'sd7, 1'b0, 1'b0);

        // Ramp: strobes on edges 4, 8, 12; steady-state output 4.
        for (int i = 0; i < 12; i++) step(1'b0, LEN'(i), 1'b0, 1'b0);

        // Saturation both ways.
        window(-5'sd16, -1, 1'b0, 1'b0);
        window(5'sd15, -1, 1'b0, 1'b0);
        window(5'sd15, -1, 1'b0, 1'b0);
        window(-5'sd16, -1, 1'b0, 1'b0);
        window(5'sd0, -1, 1'b0, 1'b0);

        // Window tag: pulses at phases 1, 3 and an underflow pulse at phase 2.
        window(5'sd0, 1, 1'b1, 1'b0);
        window(5'sd0, -1, 1'b0, 1'b0);
        window(5'sd0, -1, 1'b0, 1'b0);
        window(5'sd0, 3, 1'b1, 1'b0);
        window(5'sd0, -1, 1'b0, 1'b0);
        window(5'sd0, -1, 1'b0, 1'b0);
        window(5'sd0, 2, 1'b0, 1'b1);
        window(5'sd0, -1, 1'b0, 1'b0);

        // Mid-window reset with constant 6: aborted window yields no strobe.
        window(5'sd6, -1, 1'b0, 1'b0);
        window(5'sd6, -1, 1'b0, 1'b0);
        step(1'b0, 5'sd6, 1'b0, 1'b0);
        step(1'b0, 5'sd6, 1'b0, 1'b0);
        step(1'b1, 5'sd6, 1'b0, 1'b0);
        repeat (3) window(5'sd6, -1, 1'b0, 1'b0);

        // Constant 5 after reset: DELAY=2 instance gives 5, 5, 0, 0.
        step(1'b1, 5'sd5, 1'b0, 1'b0);
        repeat (4) window(5'sd5, -1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decimating_comb.md
# decimating_comb

- Decimating comb stage that sits directly downstream of the forward integrator in the CIC-style decimation chain.
- Consumes the integrator's saturated signed output and its overflow/underflow flags, and keeps one sample out of every `RATIO`.
- Emits the saturated difference y[n] = x[n] − x[n−DELAY] on the decimated rate, qualified by a one-cycle `VALID_O` strobe.
- Integrator saturation seen during a decimation window is reported alongside the output that window produces.

## Interface
- `LENGTH`, 5: data width in bits, signed two's complement; equals the integrator's `LENGTH`.
- `RATIO`, 4: decimation ratio R, integer ≥ 2.
- `DELAY`, 1: differential delay M in decimated samples, 1..4.
- `INPUT_REG`, 1'b1: 1 registers `DATA_I`/`OFDET_I`/`UFDET_I` before use; 0 uses them directly.

- `CLK_I` in 1: single clock.
- `RESET_I` in 1: reset, synchronous and active-high.
- `DATA_I` in `LENGTH`: signed integrator output.
- `OFDET_I` in 1: integrator overflow flag.
- `UFDET_I` in 1: integrator underflow flag.
- `DATA_O` out `LENGTH`: signed comb output; holds its value between strobes.
- `VALID_O` out 1: one-cycle strobe marking a new `DATA_O`.
- `OFDET_O` out 1: comb result clipped at +max; updates with `VALID_O`.
- `UFDET_O` out 1: comb result clipped at −min; updates with `VALID_O`.
- `SATIN_O` out 1: `OFDET_I` or `UFDET_I` was seen in the window that produced this output; updates with `VALID_O`.

## Operation
- **Input stage s:**
  - `INPUT_REG=1`: a register, reset to 0.
  - `INPUT_REG=0`: wires.
- **Phase counter `cnt`:**
  - Range 0..RATIO−1, width `$clog2(RATIO)`.
  - Resets to 0 and increments every cycle.
  - When `cnt==RATIO-1`: the decimation edge fires and `cnt` wraps to 0.
- **Window flag `win`:** ORs s.OFDET|s.UFDET every cycle, including the decimation cycle.
  - On the decimation edge it is transferred to `SATIN_O`, then cleared.
  - If a flag is present on the decimation cycle itself, it belongs to the closing window.
- **Delay line:**
  - `DELAY` entries, reset to 0, and shifts only on decimation edges.
  - Newest entry = s.DATA; oldest entry = x[n−M].
- **Arithmetic:**
  - d = s.DATA − x[n−M], computed sign-extended in `LENGTH+1` bits.
  - If d > 2^(LENGTH−1)−1: `DATA_O`=+max and `OFDET_O`=1.
  - If d < −2^(LENGTH−1): `DATA_O`=−min and `UFDET_O`=1.
  - Otherwise: `DATA_O`=d[LENGTH−1:0], and both flags 0.
  - `OFDET_O` and `UFDET_O` are never 1 together.
- **Warm-up:** the first M outputs after reset equal the captured samples, because the delay line is zero-filled. No suppression of these outputs.
- **Reset (any cycle, including mid-window):**
  - `DATA_O`=0, `VALID_O`=0, `OFDET_O`=0, `UFDET_O`=0, `SATIN_O`=0.
  - `cnt`=0, `win`=0, delay line=0, input register=0.
  - A partially accumulated window is discarded; no strobe is emitted for it.

## Timing
- All state updates on the rising edge of `CLK_I`; no combinational input-to-output path.
- **Latency:** `DATA_I` to the capturing s-value is `INPUT_REG` cycles. The result appears on `DATA_O` at the decimation edge, i.e. 1 cycle after the s-value is present.
- **Strobe:** `VALID_O` is high for exactly 1 cycle, every `RATIO` cycles.
  - The first strobe is the `RATIO`-th rising edge after the first edge with `RESET_I`=0.
- **Hold:** between strobes, `DATA_O`, `OFDET_O`, `UFDET_O` and `SATIN_O` hold their values.
- **Reset:** `RESET_I`=1 takes effect at the next edge and overrides the decimation edge in that same cycle.

## Structure
- **Package `decimating_comb_pkg`:**
  - Function `sat_max(len)`, returning the saturation constant +max.
  - Function `sat_min(len)`, returning the saturation constant −min.
  - Function `cnt_width(ratio)`.
  - Typedef `sat_flags_t`: struct {of, uf}.
- **Sub-module `sat_sub`:** combinational `LENGTH+1`-bit subtract plus clip, producing data, of and uf. It is shared with future comb stages.
- The top level holds the input register, counter, window flag, delay line and output registers.

## Test plan
Defaults unless stated: `LENGTH`=5, `RATIO`=4, `DELAY`=1, `INPUT_REG`=1.
- **Reset hold:** hold `RESET_I`=1 for 3 cycles with `DATA_I`=7.
  - Required: all outputs 0 throughout.
  - After release: `VALID_O` pulses on edges 4, 8, 12.
- **Ramp:** `DATA_I` counts 0,1,2,… per cycle (kept below 16 by reset).
  - Required: after warm-up, every `DATA_O` at a strobe is 4, with `OFDET_O`, `UFDET_O` and `SATIN_O` all 0.
- **Saturation:** drive captured samples −16 then +15.
  - Required: `DATA_O`=15 with `OFDET_O`=1.
  - Then drive +15 then −16: required `DATA_O`=−16 with `UFDET_O`=1, and `OFDET_O`=0.
- **Window tag:** 1-cycle `OFDET_I` pulse while `cnt`=1.
  - Required: next strobe has `SATIN_O`=1; the following strobe has `SATIN_O`=0.
  - Repeat with the pulse at `cnt`=3: required to be tagged on that window's strobe.
- **Mid-window reset:** `RESET_I` pulse at `cnt`=2 with constant `DATA_I`=6.
  - Required: no strobe for the aborted window.
  - First strobe after the reset gives `DATA_O`=6; the next gives 0.
- **`DELAY`=2, constant `DATA_I`=5:**
  - Required: strobed outputs 5, 5, 0, 0, …, with no flags set.
